br_annul_checker: RTL and testbench

//  Synthesizable, parametrised branch-annul checker for the soc CPU pipeline.

---
 rtl/br_annul_if.sv | 40 ++++
 rtl/br_annul_checker.sv | 120 ++++++++++++
 tb/tb_br_annul_checker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/br_annul_if.sv
// Tap bundle between the CPU core (master) and the branch-annul checker (slave).
// There is no valid/ready handshake: the checker samples every tap on every clock edge.
interface br_annul_if #(
    parameter int INSN_W = 16,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              i_br_taken;
    logic              i_insn_ce;
    logic              i_in_irq;
    logic [ADDR_W-1:0] i_i_ad;
    logic [INSN_W-1:0] i_insn_q;

    logic [CNT_W-1:0]  o_checks;
    logic [CNT_W-1:0]  o_errors;
    logic [CNT_W-1:0]  o_branches;
    logic [CNT_W-1:0]  o_irq_branches;
    logic              o_err_pulse;
    logic              o_err_sticky;
    logic [ADDR_W-1:0] o_ff_addr;
    logic [INSN_W-1:0] o_ff_insn;
    logic [3:0]        o_ff_slot;
    logic              o_ff_irq;
    logic              o_dbg_state;
    logic [3:0]        o_dbg_slot;

    modport master (
        output i_br_taken, i_insn_ce, i_in_irq, i_i_ad, i_insn_q,
        input  o_checks, o_errors, o_branches, o_irq_branches, o_err_pulse,
               o_err_sticky, o_ff_addr, o_ff_insn, o_ff_slot, o_ff_irq,
               o_dbg_state, o_dbg_slot
    );

    modport slave (
        input  i_br_taken, i_insn_ce, i_in_irq, i_i_ad, i_insn_q,
        output o_checks, o_errors, o_branches, o_irq_branches, o_err_pulse,
               o_err_sticky, o_ff_addr, o_ff_insn, o_ff_slot, o_ff_irq,
               o_dbg_state, o_dbg_slot
    );
endinterface

// File: rtl/br_annul_checker.sv
// Checks that the ANNUL_DEPTH instruction slots after each taken branch hold NOP,
// with saturating statistics counters and first-failure capture.
`ifndef CPU_NOP_INSN
`define CPU_NOP_INSN 16'h0000
`endif

module br_annul_checker #(
    parameter int               INSN_W      = 16,
    parameter int               ADDR_W      = 16,
    parameter logic [INSN_W-1:0] NOP_INSN   = `CPU_NOP_INSN,
    parameter int               ANNUL_DEPTH = 1,
    parameter bit               STALL_AWARE = 1'b0,
    parameter int               CNT_W       = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    br_annul_if.slave    bus
);
    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_ACTIVE = 1'b1;
    localparam logic [3:0]       DEPTH4    = 4'(ANNUL_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [0:0]        r_state;
    logic [3:0]        r_slot;
    logic [ADDR_W-1:0] r_addr;
    logic              r_irq;
    logic [CNT_W-1:0]  r_checks, r_errors, r_branches, r_irq_branches;
    logic              r_pulse, r_sticky;
    logic [ADDR_W-1:0] r_ff_addr;
    logic [INSN_W-1:0] r_ff_insn;
    logic [3:0]        r_ff_slot;
    logic              r_ff_irq;

    logic w_trig, w_adv, w_check, w_bad, w_last;

    assign w_trig  = bus.i_br_taken & bus.i_insn_ce;
    assign w_adv   = STALL_AWARE ? bus.i_insn_ce : 1'b1;
    assign w_check = (r_state == ST_ACTIVE) & w_adv;
    assign w_bad   = w_check & (bus.i_insn_q != NOP_INSN);
    assign w_last  = (r_slot == DEPTH4);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_slot         <= 4'd0;
            r_addr         <= '0;
            r_irq          <= 1'b0;
            r_checks       <= '0;
            r_errors       <= '0;
            r_branches     <= '0;
            r_irq_branches <= '0;
            r_pulse        <= 1'b0;
            r_sticky       <= 1'b0;
            r_ff_addr      <= '0;
            r_ff_insn      <= '0;
            r_ff_slot      <= 4'd0;
            r_ff_irq       <= 1'b0;
        end else begin
            // A retrigger still checks the current slot (below) before reloading the window.
            if (w_trig) begin
                r_state <= ST_ACTIVE;
                r_slot  <= 4'd1;
                r_addr  <= bus.i_i_ad;
                r_irq   <= bus.i_in_irq;
            end else if (w_check) begin
                if (w_last) begin
                    r_state <= ST_IDLE;
                    r_slot  <= 4'd0;
                end else begin
                    r_slot <= r_slot + 4'd1;
                end
            end

            if (i_clear) begin
                r_checks       <= '0;
                r_errors       <= '0;
                r_branches     <= '0;
                r_irq_branches <= '0;
                r_pulse        <= 1'b0;
                r_sticky       <= 1'b0;
                r_ff_addr      <= '0;
                r_ff_insn      <= '0;
                r_ff_slot      <= 4'd0;
                r_ff_irq       <= 1'b0;
            end else begin
                r_checks       <= sat_inc(r_checks, w_check);
                r_errors       <= sat_inc(r_errors, w_bad);
                r_branches     <= sat_inc(r_branches, w_trig);
                r_irq_branches <= sat_inc(r_irq_branches, w_trig & bus.i_in_irq);
                r_pulse        <= w_bad;
                if (w_bad && !r_sticky) begin
                    r_sticky  <= 1'b1;
                    r_ff_addr <= r_addr;
                    r_ff_insn <= bus.i_insn_q;
                    r_ff_slot <= r_slot;
                    r_ff_irq  <= r_irq;
                end
            end
        end
    end

    assign bus.o_checks       = r_checks;
    assign bus.o_errors       = r_errors;
    assign bus.o_branches     = r_branches;
    assign bus.o_irq_branches = r_irq_branches;
    assign bus.o_err_pulse    = r_pulse;
    assign bus.o_err_sticky   = r_sticky;
    assign bus.o_ff_addr      = r_ff_addr;
    assign bus.o_ff_insn      = r_ff_insn;
    assign bus.o_ff_slot      = r_ff_slot;
    assign bus.o_ff_irq       = r_ff_irq;
    assign bus.o_dbg_state    = r_state;
    assign bus.o_dbg_slot     = r_slot;
endmodule

// File: tb/tb_br_annul_checker.sv
// Three checker configurations share one stimulus stream; each is compared every cycle
// against a slot-countdown model, with directed scenarios pinning literal values.
module tb_br_annul_checker;
    localparam logic [15:0] NOP = 16'h4E71;
    localparam int DEP [3]  = '{1, 3, 2};
    localparam bit SA  [3]  = '{1'b0, 1'b1, 1'b0};
    localparam int CMAX[3]  = '{65535, 65535, 15};

    logic        clk, rst, clear;
    logic        br, ce, irq;
    logic [15:0] ad, insn;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    br_annul_if #(.INSN_W(16), .ADDR_W(16), .CNT_W(16)) ifa ();
    br_annul_if #(.INSN_W(16), .ADDR_W(16), .CNT_W(16)) ifb ();
    br_annul_if #(.INSN_W(16), .ADDR_W(16), .CNT_W(4))  ifc ();

    assign ifa.i_br_taken = br;  assign ifb.i_br_taken = br;  assign ifc.i_br_taken = br;
    assign ifa.i_insn_ce  = ce;  assign ifb.i_insn_ce  = ce;  assign ifc.i_insn_ce  = ce;
    assign ifa.i_in_irq   = irq; assign ifb.i_in_irq   = irq; assign ifc.i_in_irq   = irq;
    assign ifa.i_i_ad     = ad;  assign ifb.i_i_ad     = ad;  assign ifc.i_i_ad     = ad;
    assign ifa.i_insn_q   = insn; assign ifb.i_insn_q  = insn; assign ifc.i_insn_q  = insn;

    br_annul_checker #(.INSN_W(16), .ADDR_W(16), .NOP_INSN(NOP), .ANNUL_DEPTH(1),
                       .STALL_AWARE(1'b0), .CNT_W(16))
        u_a (.i_clk(clk), .i_rst(rst), .i_clear(clear), .bus(ifa));
    br_annul_checker #(.INSN_W(16), .ADDR_W(16), .NOP_INSN(NOP), .ANNUL_DEPTH(3),
                       .STALL_AWARE(1'b1), .CNT_W(16))
        u_b (.i_clk(clk), .i_rst(rst), .i_clear(clear), .bus(ifb));
    br_annul_checker #(.INSN_W(16), .ADDR_W(16), .NOP_INSN(NOP), .ANNUL_DEPTH(2),
                       .STALL_AWARE(1'b0), .CNT_W(4))
        u_c (.i_clk(clk), .i_rst(rst), .i_clear(clear), .bus(ifc));

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural model: slots still owed by the open window, plus plain counters
    int m_left[3], m_addr[3], m_irq[3];
    int m_checks[3], m_errors[3], m_br[3], m_irqb[3];
    int m_pulse[3], m_sticky[3], m_ffa[3], m_ffi[3], m_ffs[3], m_ffq[3];

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_left[k] = 0; m_addr[k] = 0; m_irq[k] = 0;
                m_checks[k] = 0; m_errors[k] = 0; m_br[k] = 0; m_irqb[k] = 0;
                m_pulse[k] = 0; m_sticky[k] = 0;
                m_ffa[k] = 0; m_ffi[k] = 0; m_ffs[k] = 0; m_ffq[k] = 0;
                started = 1'b1;
            end else begin
                bit adv, trig, chk, bad;
                int slot;
                adv  = SA[k] ? ce : 1'b1;
                trig = br & ce;
                chk  = (m_left[k] > 0) && adv;
                slot = DEP[k] - m_left[k] + 1;
                bad  = chk && (insn != NOP);
                if (clear) begin
                    m_checks[k] = 0; m_errors[k] = 0; m_br[k] = 0; m_irqb[k] = 0;
                    m_pulse[k] = 0; m_sticky[k] = 0;
                    m_ffa[k] = 0; m_ffi[k] = 0; m_ffs[k] = 0; m_ffq[k] = 0;
                end else begin
                    if (chk) m_checks[k] = sat(m_checks[k], CMAX[k]);
                    if (bad) m_errors[k] = sat(m_errors[k], CMAX[k]);
                    if (trig) m_br[k] = sat(m_br[k], CMAX[k]);
                    if (trig && irq) m_irqb[k] = sat(m_irqb[k], CMAX[k]);
                    m_pulse[k] = bad;
                    if (bad && m_sticky[k] == 0) begin
                        m_sticky[k] = 1;
                        m_ffa[k] = m_addr[k]; m_ffi[k] = int'(insn);
                        m_ffs[k] = slot;      m_ffq[k] = m_irq[k];
                    end
                end
                if (trig) begin
                    m_left[k] = DEP[k]; m_addr[k] = int'(ad); m_irq[k] = int'(irq);
                end else if (chk) begin
                    m_left[k] = m_left[k] - 1;
                end
            end
        end
    end

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int k, input logic [31:0] checks, errors, branches, irqb,
                            input logic pulse, sticky, input logic [31:0] ffa, ffi, ffs,
                            input logic ffq, dstate, input logic [3:0] dslot);
        chk($sformatf("checks[%0d]", k),   checks,   m_checks[k]);
        chk($sformatf("errors[%0d]", k),   errors,   m_errors[k]);
        chk($sformatf("branches[%0d]", k), branches, m_br[k]);
        chk($sformatf("irq_br[%0d]", k),   irqb,     m_irqb[k]);
        chk($sformatf("pulse[%0d]", k),    32'(pulse),  m_pulse[k]);
        chk($sformatf("sticky[%0d]", k),   32'(sticky), m_sticky[k]);
        chk($sformatf("ff_addr[%0d]", k),  ffa,      m_ffa[k]);
        chk($sformatf("ff_insn[%0d]", k),  ffi,      m_ffi[k]);
        chk($sformatf("ff_slot[%0d]", k),  ffs,      m_ffs[k]);
        chk($sformatf("ff_irq[%0d]", k),   32'(ffq),    m_ffq[k]);
        chk($sformatf("state[%0d]", k),    32'(dstate), (m_left[k] > 0) ? 1 : 0);
        chk($sformatf("slot[%0d]", k),     32'(dslot),
            (m_left[k] > 0) ? DEP[k] - m_left[k] + 1 : 0);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_inst(0, ifa.o_checks, ifa.o_errors, ifa.o_branches, ifa.o_irq_branches,
                     ifa.o_err_pulse, ifa.o_err_sticky, ifa.o_ff_addr, ifa.o_ff_insn,
                     ifa.o_ff_slot, ifa.o_ff_irq, ifa.o_dbg_state, ifa.o_dbg_slot);
            cmp_inst(1, ifb.o_checks, ifb.o_errors, ifb.o_branches, ifb.o_irq_branches,
                     ifb.o_err_pulse, ifb.o_err_sticky, ifb.o_ff_addr, ifb.o_ff_insn,
                     ifb.o_ff_slot, ifb.o_ff_irq, ifb.o_dbg_state, ifb.o_dbg_slot);
            cmp_inst(2, ifc.o_checks, ifc.o_errors, ifc.o_branches, ifc.o_irq_branches,
                     ifc.o_err_pulse, ifc.o_err_sticky, ifc.o_ff_addr, ifc.o_ff_insn,
                     ifc.o_ff_slot, ifc.o_ff_irq, ifc.o_dbg_state, ifc.o_dbg_slot);
        end
    end

    // driver tasks: inputs change on the falling edge, one rising edge per step
    task automatic step(input logic b, input logic c, input logic q,
                        input logic [15:0] a, input logic [15:0] ins);
        br = b; ce = c; irq = q; ad = a; insn = ins;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 16'h0, NOP);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        br = 1'b0; ce = 1'b0; irq = 1'b0; ad = '0; insn = NOP;
        @(negedge clk);
        do_reset();
        chk("reset_checks", 32'(ifa.o_checks), 0);
        chk("reset_sticky", 32'(ifa.o_err_sticky), 0);

        // clean single-slot branch
        step(1'b1, 1'b1, 1'b0, 16'h0040, NOP);
        step(1'b0, 1'b1, 1'b0, 16'h0044, NOP);
        step(1'b0, 1'b1, 1'b0, 16'h0048, NOP);
        chk("t1_checks",   32'(ifa.o_checks), 1);
        chk("t1_errors",   32'(ifa.o_errors), 0);
        chk("t1_branches", 32'(ifa.o_branches), 1);
        chk("t1_sticky",   32'(ifa.o_err_sticky), 0);

        // failing slot
        do_reset();
        step(1'b1, 1'b1, 1'b0, 16'h0100, NOP);
        step(1'b0, 1'b1, 1'b0, 16'h0104, 16'h1234);
        chk("t2_pulse",   32'(ifa.o_err_pulse), 1);
        chk("t2_errors",  32'(ifa.o_errors), 1);
        chk("t2_ff_addr", 32'(ifa.o_ff_addr), 32'h0100);
        chk("t2_ff_insn", 32'(ifa.o_ff_insn), 32'h1234);
        chk("t2_ff_slot", 32'(ifa.o_ff_slot), 1);
        step(1'b0, 1'b1, 1'b0, 16'h0108, NOP);
        chk("t2_pulse_end", 32'(ifa.o_err_pulse), 0);

        // stall-aware depth 3
        do_reset();
        step(1'b1, 1'b1, 1'b0, 16'h0200, NOP);
        step(1'b0, 1'b0, 1'b0, 16'h0204, NOP);
        step(1'b0, 1'b0, 1'b0, 16'h0204, NOP);
        chk("t3_stalled", 32'(ifb.o_checks), 0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0204, NOP);
        chk("t3_checks", 32'(ifb.o_checks), 3);
        chk("t3_errors", 32'(ifb.o_errors), 0);
        step(1'b0, 1'b1, 1'b0, 16'h0208, NOP);
        chk("t3_closed", 32'(ifb.o_checks), 3);

        // retrigger on slot 1, depth 2
        do_reset();
        step(1'b1, 1'b1, 1'b0, 16'h0300, NOP);
        step(1'b1, 1'b1, 1'b1, 16'h0304, NOP);
        step(1'b0, 1'b1, 1'b0, 16'h0308, NOP);
        chk("t4_open", 32'(ifc.o_dbg_state), 1);
        step(1'b0, 1'b1, 1'b0, 16'h030C, NOP);
        chk("t4_closed",   32'(ifc.o_dbg_state), 0);
        chk("t4_checks",   32'(ifc.o_checks), 3);
        chk("t4_branches", 32'(ifc.o_branches), 2);
        chk("t4_irq_br",   32'(ifc.o_irq_branches), 1);

        // two failures, then clear
        do_reset();
        step(1'b1, 1'b1, 1'b0, 16'h0400, NOP);
        step(1'b1, 1'b1, 1'b0, 16'h0410, 16'hAAAA);
        step(1'b0, 1'b1, 1'b0, 16'h0414, 16'hBBBB);
        chk("t5_errors",  32'(ifa.o_errors), 2);
        chk("t5_ff_insn", 32'(ifa.o_ff_insn), 32'hAAAA);
        chk("t5_ff_addr", 32'(ifa.o_ff_addr), 32'h0400);
        clear = 1'b1;
        step(1'b0, 1'b1, 1'b0, 16'h0418, NOP);
        clear = 1'b0;
        chk("t5_clr_checks", 32'(ifa.o_checks), 0);
        chk("t5_clr_errors", 32'(ifa.o_errors), 0);
        chk("t5_clr_branch", 32'(ifa.o_branches), 0);
        chk("t5_clr_sticky", 32'(ifa.o_err_sticky), 0);
        chk("t5_clr_ffinsn", 32'(ifa.o_ff_insn), 0);

        // 4-bit saturation, then reset mid-window
        do_reset();
        repeat (20) step(1'b1, 1'b1, 1'b0, 16'h0500, NOP);
        chk("t6_sat", 32'(ifc.o_branches), 32'hF);
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b0, 16'h0504, 16'h1111);
        rst = 1'b0;
        chk("t6_rst_branches", 32'(ifc.o_branches), 0);
        chk("t6_rst_state",    32'(ifc.o_dbg_state), 0);
        step(1'b0, 1'b1, 1'b0, 16'h0508, 16'h2222);
        chk("t6_no_check",  32'(ifc.o_checks), 0);
        chk("t6_no_errors", 32'(ifc.o_errors), 0);

        // randomized traffic
        do_reset();
        repeat (3000) begin
            rst   = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 49) == 0);
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)), 16'($urandom),
                 ($urandom_range(0, 9) < 6) ? NOP : 16'($urandom));
        end
        rst = 1'b0; clear = 1'b0;
        step(1'b0, 1'b1, 1'b0, 16'h0, NOP);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
